// File: rtl/calc_sequencer.sv
// Command sequencer for an external combinational 3-bit-OP calculator.
// Keeps an accumulator, issues A=acc/B=operand, and returns R/ovf over a valid/ready response channel.
module calc_sequencer #(
  parameter int W    = 16,
  parameter int CNTW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic            cmd_load_i,
  input  logic [2:0]      cmd_op_i,
  input  logic [W-1:0]    cmd_data_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [W-1:0]    rsp_r_o,
  output logic            rsp_ovf_o,
  output logic            sticky_ovf_o,
  input  logic            clr_ovf_i,
  output logic [CNTW-1:0] ops_done_o,
  output logic [W-1:0]    acc_o,
  output logic [2:0]      calc_op_o,
  output logic [W-1:0]    calc_a_o,
  output logic [W-1:0]    calc_b_o,
  input  logic [W-1:0]    calc_r_i,
  input  logic            calc_ovf_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_q;
  logic [W-1:0]    acc_q;
  logic [W-1:0]    rsp_r_q;
  logic            rsp_ovf_q;
  logic            sticky_q, sticky_d;
  logic [CNTW-1:0] ops_done_q, ops_done_d;
  logic [2:0]      calc_op_q;
  logic [W-1:0]    calc_a_q;
  logic [W-1:0]    calc_b_q;

  // Set beats clear when an overflow capture coincides with clr_ovf.
  always_comb begin
    sticky_d   = sticky_q;
    ops_done_d = ops_done_q;
    if (clr_ovf_i) begin
      sticky_d = 1'b0;
    end
    if (state_q == EXEC) begin
      if (calc_ovf_i) begin
        sticky_d = 1'b1;
      end
      if (ops_done_q != '1) begin
        ops_done_d = ops_done_q + CNTW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      rsp_r_q    <= '0;
      rsp_ovf_q  <= 1'b0;
      sticky_q   <= 1'b0;
      ops_done_q <= '0;
      calc_op_q  <= '0;
      calc_a_q   <= '0;
      calc_b_q   <= '0;
    end else begin
      sticky_q   <= sticky_d;
      ops_done_q <= ops_done_d;
      case (state_q)
        IDLE: begin
          if (cmd_valid_i) begin
            if (cmd_load_i) begin
              acc_q     <= cmd_data_i;
              rsp_r_q   <= cmd_data_i;
              rsp_ovf_q <= 1'b0;
              state_q   <= RESP;
            end else begin
              calc_op_q <= cmd_op_i;
              calc_a_q  <= acc_q;
              calc_b_q  <= cmd_data_i;
              state_q   <= EXEC;
            end
          end
        end
        // calc_* have been stable for a full cycle; R/ovf are settled here.
        EXEC: begin
          rsp_r_q   <= calc_r_i;
          rsp_ovf_q <= calc_ovf_i;
          if (!calc_ovf_i) begin
            acc_q <= calc_r_i;
          end
          state_q <= RESP;
        end
        RESP: begin
          if (rsp_ready_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready_o  = (state_q == IDLE) && !rst;
  assign rsp_valid_o  = (state_q == RESP);
  assign rsp_r_o      = rsp_r_q;
  assign rsp_ovf_o    = rsp_ovf_q;
  assign sticky_ovf_o = sticky_q;
  assign ops_done_o   = ops_done_q;
  assign acc_o        = acc_q;
  assign calc_op_o    = calc_op_q;
  assign calc_a_o     = calc_a_q;
  assign calc_b_o     = calc_b_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed, table-driven bench for calc_sequencer with a behavioural 16-bit signed calculator attached.
module tb_calc_sequencer;

  logic        clk;
  logic        rst;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_load_i;
  logic [2:0]  cmd_op_i;
  logic [15:0] cmd_data_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [15:0] rsp_r_o;
  logic        rsp_ovf_o;
  logic        sticky_ovf_o;
  logic        clr_ovf_i;
  logic [7:0]  ops_done_o;
  logic [15:0] acc_o;
  logic [2:0]  calc_op_o;
  logic [15:0] calc_a_o;
  logic [15:0] calc_b_o;
  logic [15:0] calc_r_i;
  logic        calc_ovf_i;

  int checks = 0;
  int errors = 0;

  calc_sequencer #(.W(16), .CNTW(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_load_i   (cmd_load_i),
    .cmd_op_i     (cmd_op_i),
    .cmd_data_i   (cmd_data_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_r_o      (rsp_r_o),
    .rsp_ovf_o    (rsp_ovf_o),
    .sticky_ovf_o (sticky_ovf_o),
    .clr_ovf_i    (clr_ovf_i),
    .ops_done_o   (ops_done_o),
    .acc_o        (acc_o),
    .calc_op_o    (calc_op_o),
    .calc_a_o     (calc_a_o),
    .calc_b_o     (calc_b_o),
    .calc_r_i     (calc_r_i),
    .calc_ovf_i   (calc_ovf_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the external signed calculator.
  always_comb begin
    calc_r_i   = '0;
    calc_ovf_i = 1'b0;
    case (calc_op_o)
      3'b000, 3'b100: begin
        calc_r_i   = calc_a_o + calc_b_o;
        calc_ovf_i = (calc_a_o[15] == calc_b_o[15]) && (calc_r_i[15] != calc_a_o[15]);
      end
      3'b001: begin
        calc_r_i   = calc_a_o - calc_b_o;
        calc_ovf_i = (calc_a_o[15] != calc_b_o[15]) && (calc_r_i[15] != calc_a_o[15]);
      end
      3'b101: begin
        calc_r_i   = calc_b_o - calc_a_o;
        calc_ovf_i = (calc_b_o[15] != calc_a_o[15]) && (calc_r_i[15] != calc_b_o[15]);
      end
      3'b010, 3'b011: begin
        calc_r_i   = calc_b_o[15] ? (~calc_b_o + 16'd1) : calc_b_o;
        calc_ovf_i = (calc_b_o == 16'h8000);
      end
      default: begin
        calc_r_i   = calc_a_o[15] ? (~calc_a_o + 16'd1) : calc_a_o;
        calc_ovf_i = (calc_a_o == 16'h8000);
      end
    endcase
  end

  typedef struct {
    logic        clr;
    logic        load;
    logic [2:0]  op;
    logic [15:0] data;
    logic [15:0] r;
    logic        ovf;
    logic [15:0] acc;
    logic [7:0]  ops;
    logic        sticky;
  } vec_t;

  vec_t vecs[14];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s timed out waiting for DUT", name);
  endtask

  task automatic acceptCmd(input logic load, input logic [2:0] op, input logic [15:0] data);
    int n;
    n = 0;
    @(negedge clk);
    while (!cmd_ready_o && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready_o) timeoutFail("cmd_ready");
    cmd_valid_i = 1'b1;
    cmd_load_i  = load;
    cmd_op_i    = op;
    cmd_data_i  = data;
    @(posedge clk);
    #1;
    cmd_valid_i = 1'b0;
    cmd_data_i  = 16'hDEAD;
    cmd_op_i    = 3'b111;
  endtask

  // Issues one command and returns at a negedge with rsp_valid high (or after a timeout).
  task automatic applyStimulus(input logic load, input logic [2:0] op, input logic [15:0] data,
                               input logic clrEx, output int lat);
    acceptCmd(load, op, data);
    clr_ovf_i = clrEx;
    lat = 0;
    forever begin
      @(negedge clk);
      lat++;
      if (rsp_valid_o) break;
      if (lat >= 8) begin
        timeoutFail("rsp_valid");
        break;
      end
      @(posedge clk);
      #1;
      clr_ovf_i = 1'b0;
    end
    clr_ovf_i = 1'b0;
  endtask

  task automatic finishRsp();
    rsp_ready_i = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready_i = 1'b0;
  endtask

  task automatic pulseClr();
    @(negedge clk);
    clr_ovf_i = 1'b1;
    @(posedge clk);
    #1;
    clr_ovf_i = 1'b0;
  endtask

  initial begin
    logic [15:0] expA, expB, prevAcc, holdR;
    logic [2:0]  expOp;
    int          lat;

    vecs[0]  = '{1'b0, 1'b1, 3'b000, 16'h0005, 16'h0005, 1'b0, 16'h0005, 8'd0,  1'b0};
    vecs[1]  = '{1'b0, 1'b0, 3'b000, 16'h0003, 16'h0008, 1'b0, 16'h0008, 8'd1,  1'b0};
    vecs[2]  = '{1'b0, 1'b1, 3'b000, 16'h7FFF, 16'h7FFF, 1'b0, 16'h7FFF, 8'd1,  1'b0};
    vecs[3]  = '{1'b0, 1'b0, 3'b000, 16'h0001, 16'h8000, 1'b1, 16'h7FFF, 8'd2,  1'b1};
    vecs[4]  = '{1'b1, 1'b1, 3'b000, 16'hFFF6, 16'hFFF6, 1'b0, 16'hFFF6, 8'd2,  1'b0};
    vecs[5]  = '{1'b0, 1'b0, 3'b110, 16'h1234, 16'h000A, 1'b0, 16'h000A, 8'd3,  1'b0};
    vecs[6]  = '{1'b0, 1'b1, 3'b000, 16'h8000, 16'h8000, 1'b0, 16'h8000, 8'd3,  1'b0};
    vecs[7]  = '{1'b0, 1'b0, 3'b111, 16'h0000, 16'h8000, 1'b1, 16'h8000, 8'd4,  1'b1};
    vecs[8]  = '{1'b0, 1'b0, 3'b001, 16'h0001, 16'h7FFF, 1'b1, 16'h8000, 8'd5,  1'b1};
    vecs[9]  = '{1'b1, 1'b0, 3'b011, 16'hFFFB, 16'h0005, 1'b0, 16'h0005, 8'd6,  1'b0};
    vecs[10] = '{1'b0, 1'b0, 3'b100, 16'h0010, 16'h0015, 1'b0, 16'h0015, 8'd7,  1'b0};
    vecs[11] = '{1'b0, 1'b0, 3'b101, 16'h0100, 16'h00EB, 1'b0, 16'h00EB, 8'd8,  1'b0};
    vecs[12] = '{1'b0, 1'b0, 3'b010, 16'h8000, 16'h8000, 1'b1, 16'h00EB, 8'd9,  1'b1};
    vecs[13] = '{1'b0, 1'b0, 3'b001, 16'h00EB, 16'h0000, 1'b0, 16'h0000, 8'd10, 1'b1};

    rst         = 1'b1;
    cmd_valid_i = 1'b0;
    cmd_load_i  = 1'b0;
    cmd_op_i    = 3'b000;
    cmd_data_i  = 16'h0000;
    rsp_ready_i = 1'b0;
    clr_ovf_i   = 1'b0;

    #3;
    checkOutput("reset_cmd_ready", 32'(cmd_ready_o), 32'h0);
    checkOutput("reset_rsp_valid", 32'(rsp_valid_o), 32'h0);
    checkOutput("reset_acc", 32'(acc_o), 32'h0);
    checkOutput("reset_ops_done", 32'(ops_done_o), 32'h0);
    checkOutput("reset_calc", 32'({calc_op_o, calc_a_o, calc_b_o}), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    expOp   = 3'b000;
    expA    = 16'h0000;
    expB    = 16'h0000;
    prevAcc = 16'h0000;
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].clr) begin
        pulseClr();
      end
      applyStimulus(vecs[i].load, vecs[i].op, vecs[i].data, 1'b0, lat);
      if (!vecs[i].load) begin
        expOp = vecs[i].op;
        expA  = prevAcc;
        expB  = vecs[i].data;
      end
      checkOutput($sformatf("v%0d_latency", i), 32'(lat), vecs[i].load ? 32'd1 : 32'd2);
      checkOutput($sformatf("v%0d_rsp_r", i), 32'(rsp_r_o), 32'(vecs[i].r));
      checkOutput($sformatf("v%0d_rsp_ovf", i), 32'(rsp_ovf_o), 32'(vecs[i].ovf));
      checkOutput($sformatf("v%0d_acc", i), 32'(acc_o), 32'(vecs[i].acc));
      checkOutput($sformatf("v%0d_ops_done", i), 32'(ops_done_o), 32'(vecs[i].ops));
      checkOutput($sformatf("v%0d_sticky", i), 32'(sticky_ovf_o), 32'(vecs[i].sticky));
      checkOutput($sformatf("v%0d_calc_op", i), 32'(calc_op_o), 32'(expOp));
      checkOutput($sformatf("v%0d_calc_a", i), 32'(calc_a_o), 32'(expA));
      checkOutput($sformatf("v%0d_calc_b", i), 32'(calc_b_o), 32'(expB));
      checkOutput($sformatf("v%0d_cmd_ready", i), 32'(cmd_ready_o), 32'h0);
      finishRsp();
      prevAcc = vecs[i].acc;
    end

    // Clear and overflow capture in the same cycle: set must win.
    pulseClr();
    @(negedge clk);
    checkOutput("clr_sticky", 32'(sticky_ovf_o), 32'h0);
    applyStimulus(1'b1, 3'b000, 16'h7FFF, 1'b0, lat);
    finishRsp();
    applyStimulus(1'b0, 3'b000, 16'h0001, 1'b1, lat);
    checkOutput("clr_vs_set_sticky", 32'(sticky_ovf_o), 32'h1);
    checkOutput("clr_vs_set_ops", 32'(ops_done_o), 32'd11);
    finishRsp();

    // Response backpressure with a competing command held on the input.
    applyStimulus(1'b1, 3'b000, 16'h0010, 1'b0, lat);
    finishRsp();
    applyStimulus(1'b0, 3'b000, 16'h0005, 1'b0, lat);
    holdR       = rsp_r_o;
    checkOutput("bp_first_r", 32'(holdR), 32'h0015);
    cmd_valid_i = 1'b1;
    cmd_load_i  = 1'b1;
    cmd_data_i  = 16'hFFFF;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput($sformatf("bp%0d_rsp_valid", k), 32'(rsp_valid_o), 32'h1);
      checkOutput($sformatf("bp%0d_rsp_r", k), 32'(rsp_r_o), 32'h0015);
      checkOutput($sformatf("bp%0d_cmd_ready", k), 32'(cmd_ready_o), 32'h0);
    end
    cmd_valid_i = 1'b0;
    finishRsp();
    @(negedge clk);
    checkOutput("bp_after_rsp_valid", 32'(rsp_valid_o), 32'h0);
    checkOutput("bp_after_cmd_ready", 32'(cmd_ready_o), 32'h1);
    checkOutput("bp_after_acc", 32'(acc_o), 32'h0015);
    checkOutput("bp_after_ops", 32'(ops_done_o), 32'd12);

    // Reset while an execute is in flight.
    acceptCmd(1'b0, 3'b000, 16'h0001);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_exec_rsp_valid", 32'(rsp_valid_o), 32'h0);
    checkOutput("rst_exec_acc", 32'(acc_o), 32'h0);
    checkOutput("rst_exec_calc", 32'({calc_op_o, calc_a_o, calc_b_o}), 32'h0);
    checkOutput("rst_exec_cmd_ready", 32'(cmd_ready_o), 32'h1);
    checkOutput("rst_exec_ops", 32'(ops_done_o), 32'h0);
    checkOutput("rst_exec_sticky", 32'(sticky_ovf_o), 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput($sformatf("rst_exec_quiet%0d", k), 32'(rsp_valid_o), 32'h0);
    end

    // ops_done saturates at all-ones.
    applyStimulus(1'b1, 3'b000, 16'h0000, 1'b0, lat);
    finishRsp();
    for (int k = 1; k <= 258; k++) begin
      applyStimulus(1'b0, 3'b000, 16'h0000, 1'b0, lat);
      if (k == 254) checkOutput("sat_254", 32'(ops_done_o), 32'd254);
      if (k == 255) checkOutput("sat_255", 32'(ops_done_o), 32'd255);
      finishRsp();
    end
    checkOutput("sat_final", 32'(ops_done_o), 32'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
